// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One radix-2 step per cycle over a shared 2*WIDTH accumulator, sign fixup at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, dz, neg_res, neg_rem;

    logic               accept, b_zero, sgn;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_r, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

    assign accept = (state == IDLE) && start && !flush;
    assign b_zero = (portB == '0);
    assign sgn    = ~op[0];
    assign abs_a  = (sgn && portA[WIDTH-1]) ? (~portA + 1'b1) : portA;
    assign abs_b  = (sgn && portB[WIDTH-1]) ? (~portB + 1'b1) : portB;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = (op[1] && b_zero) ? FIXUP : CALC;
            CALC: begin
                if (flush)                         state_n = IDLE;
                else if (cnt == CW'(WIDTH - 1))    state_n = FIXUP;
            end
            FIXUP:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Multiply keeps the multiplier in acc's low half and shifts the product in from the top;
    // divide shifts the dividend out of the low half while quotient bits shift in.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step = {mul_sum, acc[WIDTH-1:1]};
        div_r    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_r - {1'b0, opnd};
        div_step = div_diff[WIDTH] ? {div_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod = neg_res ? (~acc + 1'b1) : acc;
        quo  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (dz) begin
            fix_hi = acc[2*WIDTH-1:WIDTH];
            fix_lo = acc[WIDTH-1:0];
        end else if (is_div) begin
            fix_hi = rem;
            fix_lo = quo;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            dz      <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            is_div  <= op[1];
            dz      <= op[1] && b_zero;
            neg_res <= sgn && (portA[WIDTH-1] ^ portB[WIDTH-1]);
            neg_rem <= sgn && portA[WIDTH-1];
            // Divide by zero parks the raw dividend and an all-ones quotient for FIXUP to copy.
            if (op[1] && b_zero) begin
                acc  <= {portA, {WIDTH{1'b1}}};
                opnd <= '0;
            end else if (op[1]) begin
                acc  <= {{WIDTH{1'b0}}, abs_a};
                opnd <= abs_b;
            end else begin
                acc  <= {{WIDTH{1'b0}}, abs_b};
                opnd <= abs_a;
            end
        end else if (state == CALC) begin
            acc <= is_div ? div_step : mul_step;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= (state == FIXUP) && !flush;
            if ((state == FIXUP) && !flush) begin
                hi       <= fix_hi;
                lo       <= fix_lo;
                div_zero <= dz;
            end else if (state == IDLE) begin
                if (hi_we)  hi <= wdata;
                if (lo_we)  lo <= wdata;
                if (accept) div_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: transaction-level reference model compared every
// cycle, plus directed operations with hand-computed results and completion cycles.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] portA = '0, portB = '0, wdata = '0;
    logic        flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op), .portA(portA), .portB(portB),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference result {div_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: begin p = sa * sb; return {1'b0, p}; end
            2'b01: begin p = ua * ub; return {1'b0, p}; end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                p = ua / ub;
                ua = ua % ub;
                return {1'b0, ua[31:0], p[31:0]};
            end
        endcase
    endfunction

    // Model: an accepted op completes after 33 cycles (1 for divide by zero).
    int          m_cnt = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_dz = 1'b0, m_done = 1'b0, p_dz = 1'b0;
    logic [64:0] res;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_cnt <= 0; m_hi <= '0; m_lo <= '0; m_dz <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                if (flush) m_cnt <= 0;
                else if (m_cnt == 1) begin
                    m_cnt <= 0; m_hi <= p_hi; m_lo <= p_lo; m_dz <= p_dz; m_done <= 1'b1;
                end else m_cnt <= m_cnt - 1;
            end else begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
                if (start && !flush) begin
                    res = ref_result(op, portA, portB);
                    p_dz  <= res[64];
                    p_hi  <= res[63:32];
                    p_lo  <= res[31:0];
                    m_dz  <= 1'b0;
                    m_cnt <= res[64] ? 1 : 33;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("cyc busy", busy, m_cnt > 0);
            chk("cyc done", done, m_done);
            chk("cyc div_zero", div_zero, m_dz);
            chk("cyc hi", hi, m_hi);
            chk("cyc lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int from, output int at);
        int n;
        n = from;
        forever begin
            @(negedge CLK);
            if (done || n >= 200) break;
            tick();
            n++;
        end
        at = n;
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n, input logic [31:0] eh,
                          input logic [31:0] el, input logic edz, input bit mid_we);
        int n;
        start = 1'b1; op = o; portA = a; portB = b;
        if (mid_we) begin lo_we = 1'b1; wdata = 32'h0000A5A5; end
        tick();
        start = 1'b0; lo_we = 1'b0;
        if (mid_we) begin
            repeat (4) tick();
            hi_we = 1'b1; wdata = 32'h0000DEAD;
            tick();
            hi_we = 1'b0;
            wait_done(6, n);
        end else begin
            wait_done(1, n);
        end
        chk({nm, " done cycle"}, n, exp_n);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        chk({nm, " div_zero"}, div_zero, edz);
        tick();
    endtask

    initial begin
        int n1, n2;
        bit saw;
        repeat (3) tick();
        @(negedge CLK);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset div_zero", div_zero, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        tick();
        nRST = 1'b1;
        chk_on = 1'b1;
        tick();

        run_op("MULTU max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 0, 0);
        run_op("MULT -7*3", 2'b00, 32'hFFFFFFF9, 32'd3, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1);

        lo_we = 1'b1; wdata = 32'h00001234;
        tick();
        lo_we = 1'b0;
        @(negedge CLK);
        chk("lo_we after done", lo, 32'h00001234);
        tick();

        run_op("MULT min*min", 2'b00, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h0, 0, 0);
        run_op("DIV -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        run_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 0, 0);
        run_op("DIV min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 0, 0);
        run_op("DIVU 5/0", 2'b11, 32'd5, 32'd0, 2, 32'd5, 32'hFFFFFFFF, 1, 0);
        run_op("DIVU 100/7 again", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 0, 0);

        // Flush at cycle 10: no completion, hi/lo stay 2/14.
        start = 1'b1; op = 2'b01; portA = 32'd3; portB = 32'd5;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge CLK);
        chk("flush busy drop", busy, 0);
        saw = 1'b0;
        repeat (40) begin
            tick();
            @(negedge CLK);
            saw |= done;
        end
        chk("flush no done", saw, 0);
        chk("flush hi kept", hi, 32'd2);
        chk("flush lo kept", lo, 32'd14);
        tick();

        // start held high through the first done cycle.
        start = 1'b1; op = 2'b01; portA = 32'd2; portB = 32'd3;
        tick();
        portA = 32'd7; portB = 32'd9;
        wait_done(1, n1);
        chk("b2b first done cycle", n1, 34);
        chk("b2b first lo", lo, 32'd6);
        tick();
        start = 1'b0;
        wait_done(n1 + 1, n2);
        chk("b2b second done cycle", n2, 68);
        chk("b2b second lo", lo, 32'd63);
        tick();

        hi_we = 1'b1; wdata = 32'h00000055;
        tick();
        hi_we = 1'b0;
        start = 1'b1; op = 2'b00; portA = 32'd11; portB = 32'd13;
        tick();
        start = 1'b0;
        repeat (9) tick();
        nRST = 1'b0;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset done", done, 0);
        chk("mid reset div_zero", div_zero, 0);
        chk("mid reset hi", hi, 0);
        chk("mid reset lo", lo, 0);
        tick();
        nRST = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        chk("post reset idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
